// File: rtl/blink_round_ctrl.sv
// Blink game round controller: sweeps one lit LED across an 8-LED bar and judges button presses
// against a target position, producing the hit count/level and the lose flag.
module blink_round_ctrl #(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned PERIOD_STEP = 2_000_000,
  parameter int unsigned TARGET      = 3,
  parameter int unsigned HIT_HOLD    = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       end_cond,
  output logic [7:0] led,
  output logic [3:0] x,
  output logic       lose
);

  typedef enum logic [1:0] {StRun, StHold, StDone} state_e;

  localparam logic [2:0] TargetPos = TARGET[2:0];

  state_e      state_q, state_d;
  logic        btn_q;
  logic        armed_q, armed_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] hold_q, hold_d;
  logic [2:0]  pos_q, pos_d;
  logic [7:0]  led_q, led_d;
  logic [3:0]  x_q, x_d;
  logic        lose_q, lose_d;

  logic        press;
  logic [31:0] period;
  logic        tick_last;
  logic [2:0]  pos_nxt;

  // armed blocks a press from a button that was already down when reset was applied
  assign press     = btn & ~btn_q & armed_q;
  assign period    = BASE_PERIOD - 32'(x_q) * PERIOD_STEP;
  assign tick_last = (tick_q == period - 32'd1);
  assign pos_nxt   = pos_q + 3'd1;
  assign armed_d   = armed_q | ~btn;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    led_d   = led_q;
    x_d     = x_q;
    lose_d  = lose_q;
    unique case (state_q)
      StRun: begin
        if (end_cond) begin
          state_d = StDone;
        end else if (press) begin
          // a press on the terminal tick is judged before the advance, which is dropped
          if (pos_q == TargetPos) begin
            x_d     = (x_q == 4'hF) ? x_q : x_q + 4'd1;
            tick_d  = 32'd0;
            hold_d  = 32'd0;
            led_d   = 8'hFF;
            state_d = StHold;
          end else begin
            lose_d  = 1'b1;
            state_d = StDone;
          end
        end else if (tick_last) begin
          tick_d = 32'd0;
          pos_d  = pos_nxt;
          led_d  = 8'h01 << pos_nxt;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      StHold: begin
        if (end_cond) begin
          state_d = StDone;
        end else if (hold_q == HIT_HOLD - 32'd1) begin
          hold_d  = 32'd0;
          tick_d  = 32'd0;
          pos_d   = 3'd0;
          led_d   = 8'h01;
          state_d = StRun;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      StDone: begin
      end
      default: state_d = StDone;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      btn_q   <= 1'b0;
      armed_q <= ~btn;
      tick_q  <= 32'd0;
      hold_q  <= 32'd0;
      pos_q   <= 3'd0;
      led_q   <= 8'h01;
      x_q     <= 4'h0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      x_q     <= x_d;
      lose_q  <= lose_d;
    end
  end

  assign led  = led_q;
  assign x    = x_q;
  assign lose = lose_q;

endmodule
